ysyx_24100012_ifu: RTL and testbench
====================================

YSYX_24100012_IFU -- requirements
Module: ysyx_24100012_ifu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the instruction, PC and address buses.
REQ-002 Parameter RESET_PC, default 32'h8000_0000, SHALL set the PC loaded on reset.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_req_valid  out  1  fetch request
- mem_req_addr  out  DATA_WIDTH  fetch address (word aligned)
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  DATA_WIDTH  fetched word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- instruction  out  DATA_WIDTH  registered instruction word to the decoder
- inst_pc  out  DATA_WIDTH  PC of the instruction
- redirect_valid  in  1  branch/jump/jalr redirect from execute
- redirect_pc  in  DATA_WIDTH  redirect target
- fetch_misalign  out  1  one-cycle pulse: redirect target had bits[1:0] != 0

Function
REQ-005 The FSM SHALL have the states IDLE, REQ, WAIT and HOLD; IDLE lasts exactly one cycle after reset and then goes to REQ.
REQ-006 In REQ: mem_req_valid=1 and mem_req_addr=pc; mem_req_ready=1 -> WAIT.
REQ-007 In WAIT: mem_resp_valid=1 -> instruction<=mem_resp_data, inst_pc<=pc, inst_valid<=1, go to HOLD.
REQ-008 In HOLD: instruction, inst_pc and inst_valid SHALL remain stable until inst_ready=1; then pc<=pc+4 (mod 2^DATA_WIDTH, wrapping to 0), inst_valid<=0, and the state goes to REQ.
REQ-009 Best-case latency SHALL be: request accepted in cycle N, response in N+1, inst_valid high in N+2; throughput is 1 instruction per 3 cycles minimum.
REQ-010 Redirect SHALL have priority over all other events in every state: pc<={redirect_pc[DW-1:2],2'b00}, and fetch_misalign pulses if redirect_pc[1:0]!=0.
REQ-011 Redirect in REQ without mem_req_ready SHALL withdraw the request; the state stays REQ and the next cycle uses the new pc.
REQ-012 Redirect in REQ with mem_req_ready, or in WAIT, SHALL set the internal flag drop=1 and go to WAIT. The next mem_resp_valid is discarded (inst_valid stays 0), drop clears, and the state goes to REQ.
REQ-013 Redirect in HOLD, including in the same cycle as inst_ready, SHALL clear inst_valid next cycle, go to REQ, and suppress the pc+4 increment.
REQ-014 mem_resp_valid SHALL be ignored in IDLE, REQ and HOLD.
REQ-015 inst_valid SHALL never depend combinationally on inst_ready (no combinational path ready->valid).

Reset
REQ-016 On rst=1 at a rising edge, the block SHALL set: pc=RESET_PC, state=IDLE, drop=0, inst_valid=0, instruction=0, inst_pc=0, mem_req_valid=0, fetch_misalign=0.
REQ-017 Reset mid-transaction SHALL abandon any outstanding request; a late response arriving in IDLE is ignored per REQ-014.
REQ-018 mem_req_addr SHALL equal pc in every state, including during reset.

Structure
REQ-019 The shared package ysyx_24100012_pkg SHALL hold RESET_PC, the IFU state enum and the RV32 opcode constants, shared with the decoder.
REQ-020 The block SHALL be a single module with no sub-module; pc, state, drop and the output register are local.

Verification
REQ-021 After reset with zero-wait memory returning 32'h00100093: first mem_req_addr=32'h8000_0000; inst_valid rises in the 3rd cycle after IDLE; instruction=32'h00100093 and inst_pc=32'h8000_0000.
REQ-022 Hold inst_ready=0 for 5 cycles in HOLD: instruction and inst_pc stay stable and no new mem_req_valid is issued; after ready, the next address is 32'h8000_0004.
REQ-023 Redirect to 32'h8000_0100 while in WAIT: the pending response 32'hDEADBEEF is dropped, and the next request address is 32'h8000_0100 with no inst_valid in between.
REQ-024 Redirect to 32'h8000_0042 coincident with inst_ready in HOLD: fetch_misalign pulses for 1 cycle, and the next address is 32'h8000_0040, not pc+4.
REQ-025 Assert rst during WAIT, then deliver a response one cycle later: no inst_valid; the refetch starts at 32'h8000_0000.
REQ-026 pc=32'hFFFF_FFFC consumed: the next mem_req_addr is 32'h0000_0000.

Source files
------------

// File: rtl/ysyx_24100012_pkg.sv
// rtl/ysyx_24100012_pkg.sv - shared constants and types for the ysyx_24100012 core front end
package ysyx_24100012_pkg;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } ifu_state_e;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/ysyx_24100012_ifu.sv
// rtl/ysyx_24100012_ifu.sv - instruction fetch unit: one outstanding fetch, registered instruction to decode
module ysyx_24100012_ifu #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = ysyx_24100012_pkg::RESET_PC
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req_valid,
   output logic [DATA_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [DATA_WIDTH-1:0] inst_pc,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  fetch_misalign
);
   import ysyx_24100012_pkg::*;

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   ifu_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  drop_q, drop_d;
   logic                  inst_valid_q, inst_valid_d;
   logic [DATA_WIDTH-1:0] instruction_q, instruction_d;
   logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
   logic                  mem_req_valid_q, mem_req_valid_d;
   logic                  fetch_misalign_q, fetch_misalign_d;
   logic [DATA_WIDTH-1:0] redirect_target;

   // Low two bits are forced to zero; the misalignment is only reported.
   assign redirect_target = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

   // Next-state logic: redirect wins in every state, then the normal fetch handshake.
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      drop_d           = drop_q;
      inst_valid_d     = inst_valid_q;
      instruction_d    = instruction_q;
      inst_pc_d        = inst_pc_q;
      fetch_misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

      if (redirect_valid) begin
         pc_d = redirect_target;
      end

      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            // Without ready a redirect simply retargets the still-pending request.
            if (mem_req_ready) begin
               state_d = WAIT;
               drop_d  = redirect_valid;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               // A response landing together with the redirect is the one to throw
               // away, so there is nothing left to wait for.
               if (mem_resp_valid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (mem_resp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  instruction_d = mem_resp_data;
                  inst_pc_d     = pc_q;
                  inst_valid_d  = 1'b1;
                  state_d       = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               inst_valid_d = 1'b0;
               state_d      = REQ;
            end else if (inst_ready) begin
               inst_valid_d = 1'b0;
               pc_d         = pc_q + PC_STEP;
               state_d      = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mem_req_valid_d = (state_d == REQ);
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         pc_q             <= RESET_PC;
         drop_q           <= 1'b0;
         inst_valid_q     <= 1'b0;
         instruction_q    <= '0;
         inst_pc_q        <= '0;
         mem_req_valid_q  <= 1'b0;
         fetch_misalign_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         drop_q           <= drop_d;
         inst_valid_q     <= inst_valid_d;
         instruction_q    <= instruction_d;
         inst_pc_q        <= inst_pc_d;
         mem_req_valid_q  <= mem_req_valid_d;
         fetch_misalign_q <= fetch_misalign_d;
      end
   end

   assign mem_req_valid  = mem_req_valid_q;
   assign mem_req_addr   = pc_q;
   assign inst_valid     = inst_valid_q;
   assign instruction    = instruction_q;
   assign inst_pc        = inst_pc_q;
   assign fetch_misalign = fetch_misalign_q;

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// tb/tb_ysyx_24100012_ifu.sv - self-checking bench for ysyx_24100012_ifu
module tb_ysyx_24100012_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] instruction;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_misalign;

   int checks = 0;
   int errors = 0;

   // memory model knobs
   logic mem_rand_ready = 1'b0;
   int   mem_fixed_lat  = 0;
   logic force_dead     = 1'b0;

   ysyx_24100012_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .instruction    (instruction),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_misalign (fetch_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RST_PC) return 32'h0010_0093;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // Memory: one request in flight, response 1+lat cycles after acceptance.
   initial begin : mem_model
      logic        pend;
      int          cnt;
      logic [31:0] paddr;
      pend = 1'b0;
      cnt = 0;
      paddr = '0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data = '0;
      forever begin
         @(negedge clk);
         #1;
         mem_resp_valid = 1'b0;
         if (pend) begin
            if (cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data = force_dead ? 32'hDEAD_BEEF : mem_word(paddr);
               pend = 1'b0;
            end else begin
               cnt = cnt - 1;
            end
         end
         mem_req_ready = mem_rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (mem_req_valid === 1'b1 && mem_req_ready && rst === 1'b0) begin
            pend = 1'b1;
            paddr = mem_req_addr;
            cnt = mem_rand_ready ? int'($urandom_range(0, 2)) : mem_fixed_lat;
         end
      end
   end

   task automatic wait_delivery(input int max_cycles, input string name);
      int n;
      n = 0;
      while (inst_valid !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: inst_valid=%b after %0d cycles, required 1", name, inst_valid, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      inst_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h1234_5677;
      repeat (3) @(negedge clk);
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b required 0", inst_valid); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b required 0", mem_req_valid); end
      checks++; if (mem_req_addr !== RST_PC) begin errors++; $display("FAIL reset_req_addr: got %h required %h", mem_req_addr, RST_PC); end
      checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h required 0", instruction); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h required 0", inst_pc); end
      checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b required 0", fetch_misalign); end
   endtask

   task automatic test_first_fetch();
      rst = 1'b0;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_req_valid: got %b required 0", mem_req_valid); end
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b required 1", mem_req_valid); end
      checks++; if (mem_req_addr !== RST_PC) begin errors++; $display("FAIL first_req_addr: got %h required %h", mem_req_addr, RST_PC); end
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL first_wait: inst_valid=%b req_valid=%b required 0/0", inst_valid, mem_req_valid); end
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_inst_valid: got %b required 1", inst_valid); end
      checks++; if (instruction !== 32'h0010_0093) begin errors++; $display("FAIL first_instruction: got %h required 00100093", instruction); end
      checks++; if (inst_pc !== RST_PC) begin errors++; $display("FAIL first_inst_pc: got %h required %h", inst_pc, RST_PC); end
   endtask

   task automatic test_hold_stall();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b1 || instruction !== 32'h0010_0093 || inst_pc !== RST_PC || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable[%0d]: valid=%b inst=%h pc=%h req=%b required 1/00100093/%h/0", i, inst_valid, instruction, inst_pc, mem_req_valid, RST_PC);
         end
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b required 0", inst_valid); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL hold_next_addr: req=%b addr=%h required 1/80000004", mem_req_valid, mem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      mem_fixed_lat = 1;
      force_dead = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_wait: valid=%b req=%b required 0/0", inst_valid, mem_req_valid); end
      @(negedge clk);
      force_dead = 1'b0;
      mem_fixed_lat = 0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_no_valid: got %b required 0", inst_valid); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL drop_next_addr: req=%b addr=%h required 1/80000100", mem_req_valid, mem_req_addr); end
      wait_delivery(10, "drop_refetch");
      checks++; if (inst_pc !== 32'h8000_0100 || instruction !== mem_word(32'h8000_0100)) begin errors++; $display("FAIL drop_refetch_data: pc=%h inst=%h required 80000100/%h", inst_pc, instruction, mem_word(32'h8000_0100)); end
   endtask

   task automatic test_redirect_hold();
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0042;
      @(negedge clk);
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rh_valid_clear: got %b required 0", inst_valid); end
      checks++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL rh_misalign_pulse: got %b required 1", fetch_misalign); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0040) begin errors++; $display("FAIL rh_next_addr: req=%b addr=%h required 1/80000040", mem_req_valid, mem_req_addr); end
      @(negedge clk);
      checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL rh_misalign_end: got %b required 0", fetch_misalign); end
      wait_delivery(10, "rh_fetch");
      checks++; if (inst_pc !== 32'h8000_0040) begin errors++; $display("FAIL rh_inst_pc: got %h required 80000040", inst_pc); end
   endtask

   task automatic test_reset_mid();
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      mem_fixed_lat = 1;
      checks++; if (mem_req_addr !== 32'h8000_0044) begin errors++; $display("FAIL rm_req_addr: got %h required 80000044", mem_req_addr); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_fixed_lat = 0;
      checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== RST_PC) begin errors++; $display("FAIL rm_idle: valid=%b req=%b addr=%h required 0/0/%h", inst_valid, mem_req_valid, mem_req_addr, RST_PC); end
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rm_late_resp_ignored: inst_valid=%b required 0", inst_valid); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin errors++; $display("FAIL rm_refetch: req=%b addr=%h required 1/%h", mem_req_valid, mem_req_addr, RST_PC); end
      wait_delivery(10, "rm_fetch");
      checks++; if (inst_pc !== RST_PC || instruction !== 32'h0010_0093) begin errors++; $display("FAIL rm_data: pc=%h inst=%h required %h/00100093", inst_pc, instruction, RST_PC); end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_addr: got %h required fffffffc", mem_req_addr); end
      wait_delivery(10, "wrap_fetch");
      checks++; if (inst_pc !== 32'hFFFF_FFFC || instruction !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_data: pc=%h inst=%h required fffffffc/%h", inst_pc, instruction, mem_word(32'hFFFF_FFFC)); end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: req=%b addr=%h required 1/00000000", mem_req_valid, mem_req_addr); end
   endtask

   // Program-order scoreboard: the next delivered / requested PC follows from
   // consumed instructions and redirects alone.
   task automatic test_random();
      logic [31:0] exp_pc, prev_rpc, prev_inst, prev_ipc, rpc;
      logic        prev_valid, prev_ready, prev_redir, exp_mis;
      int          deliveries, stall;
      rst = 1'b1;
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mem_rand_ready = 1'b1;
      exp_pc = RST_PC;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
      prev_rpc = '0; prev_inst = '0; prev_ipc = '0;
      deliveries = 0;
      stall = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         exp_mis = prev_redir && (prev_rpc[1:0] != 2'b00);
         checks++; if (fetch_misalign !== exp_mis) begin errors++; $display("FAIL rnd_misalign@%0d: got %b required %b", i, fetch_misalign, exp_mis); end
         if (prev_valid && !prev_ready && !prev_redir) begin
            checks++;
            if (inst_valid !== 1'b1 || instruction !== prev_inst || inst_pc !== prev_ipc) begin
               errors++;
               $display("FAIL rnd_stable@%0d: valid=%b inst=%h pc=%h required 1/%h/%h", i, inst_valid, instruction, inst_pc, prev_inst, prev_ipc);
            end
         end
         if (prev_valid && (prev_ready || prev_redir)) begin
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rnd_clear@%0d: inst_valid=%b required 0", i, inst_valid); end
         end
         if (inst_valid === 1'b1 && !prev_valid) begin
            deliveries++;
            stall = 0;
            checks++;
            if (inst_pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL rnd_deliver@%0d: pc=%h inst=%h required %h/%h", i, inst_pc, instruction, exp_pc, mem_word(exp_pc));
            end
         end else begin
            stall++;
         end
         checks++; if (mem_req_valid === 1'b1 && inst_valid === 1'b1) begin errors++; $display("FAIL rnd_req_in_hold@%0d: req and inst_valid both high, required exclusive", i); end
         checks++; if (stall > 60) begin errors++; $display("FAIL rnd_watchdog@%0d: %0d cycles without delivery, required <= 60", i, stall); stall = 0; end

         inst_ready = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         rpc = 32'h8000_0000 + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
         redirect_pc = rpc;
         #2;
         if (mem_req_valid === 1'b1) begin
            checks++; if (mem_req_addr !== exp_pc) begin errors++; $display("FAIL rnd_req_addr@%0d: got %h required %h", i, mem_req_addr, exp_pc); end
         end
         if (redirect_valid) exp_pc = {rpc[31:2], 2'b00};
         else if (inst_valid === 1'b1 && inst_ready) exp_pc = exp_pc + 32'd4;
         prev_valid = (inst_valid === 1'b1);
         prev_ready = inst_ready;
         prev_redir = redirect_valid;
         prev_rpc = rpc;
         prev_inst = instruction;
         prev_ipc = inst_pc;
      end
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      mem_rand_ready = 1'b0;
      checks++; if (deliveries < 50) begin errors++; $display("FAIL rnd_throughput: %0d deliveries, required >= 50", deliveries); end
   endtask

   initial begin
      rst = 1'b1;
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      test_reset();
      test_first_fetch();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
